// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the 3x3 convolution stage.
//   KERNEL_TAPS      number of window taps (3x3)
//   ADDR_NORM_MUL    coefficient-port address of the normalisation multiplier
//   ADDR_NORM_SHIFT  coefficient-port address of the normalisation shift
//   DEF_*            reset contents of both register banks (approx. divide by 9)
//   conv_state_e     coefficient-commit FSM states
package conv_pkg;

    localparam int KERNEL_TAPS = 9;

    localparam logic [3:0] ADDR_NORM_MUL   = 4'd9;
    localparam logic [3:0] ADDR_NORM_SHIFT = 4'd10;

    localparam int DEF_COEF       = 1;
    localparam int DEF_NORM_MUL   = 57;
    localparam int DEF_NORM_SHIFT = 9;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } conv_state_e;

endpackage

// File: rtl/conv_normalize.sv
// conv_normalize: combinational normalisation (pipeline stage S4 datapath).
//   norm = (sum * norm_mul + round) >>> norm_shift, round = 1 << (shift-1) when
//   shift != 0 (round half up), arithmetic shift.
// Optional build macro CONV_SATURATE_EN:
//   defined   -> result clamped to [0, 2^DATA_W-1]
//   undefined -> low DATA_W bits of norm (wraps, no comparators)
// Ports:
//   sum_i         signed window sum, ACC_W bits
//   norm_mul_i    unsigned multiplier, NORM_W bits
//   norm_shift_i  right shift, 0..31
//   pixel_o       normalised pixel, DATA_W bits
module conv_normalize #(
    parameter int DATA_W = 8,
    parameter int NORM_W = 8,
    parameter int ACC_W  = 21
) (
    input  logic signed [ACC_W-1:0]  sum_i,
    input  logic        [NORM_W-1:0] norm_mul_i,
    input  logic        [4:0]        norm_shift_i,
    output logic        [DATA_W-1:0] pixel_o
);

    // Room for the full product, a sign bit for the zero-extended multiplier
    // and a rounding term of up to 2^30 when the shift is 31.
    localparam int PROD_W = ACC_W + NORM_W + 3;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    logic signed [PROD_W-1:0] biased;

    always_comb begin
        prod = PROD_W'(sum_i) * PROD_W'($signed({1'b0, norm_mul_i}));
        rnd  = '0;
        if (norm_shift_i != 5'd0) begin
            rnd = PROD_W'(1) << (norm_shift_i - 5'd1);
        end
        biased = prod + rnd;
    end

`ifdef CONV_SATURATE_EN
    localparam logic signed [PROD_W-1:0] PIX_MAX = PROD_W'((1 << DATA_W) - 1);

    logic signed [PROD_W-1:0] norm;

    always_comb begin
        norm = biased >>> norm_shift_i;
        if (norm < 0) begin
            pixel_o = '0;
        end else if (norm > PIX_MAX) begin
            pixel_o = '1;
        end else begin
            pixel_o = norm[DATA_W-1:0];
        end
    end
`else
    assign pixel_o = DATA_W'(biased >>> norm_shift_i);
`endif

endmodule

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: 3x3 convolution stage with programmable signed taps and a
// multiply-and-shift normaliser. Four registered stages:
//   S1 per-tap products, S2 row sums, S3 window sum, S4 normalised output.
// Optional build macro CONV_SATURATE_EN selects clamping in the normaliser.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_pixel_data[_valid]      3x3 window in (tap k at [k*DATA_W +: DATA_W])
//   o_pixel_data_ready        window accepted when valid & ready
//   o_convolved_data[_valid]  filtered pixel out, held until accepted
//   i_convolved_data_ready    downstream ready
//   i_coef_wr/addr/data       shadow bank write port
//   i_coef_commit             request shadow-to-active copy
//   o_coef_busy               commit in progress
//   o_fsm_state               commit FSM state (debug)
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never depends on ready, and a raised valid with its data stays
// unchanged until it transfers. The whole pipeline moves only when the output
// register is empty or being accepted (adv), so bubbles are kept in place.
module conv3x3_filter
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int NORM_W = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [KERNEL_TAPS*DATA_W-1:0]   i_pixel_data,
    input  logic                            i_pixel_data_valid,
    output logic                            o_pixel_data_ready,
    output logic [DATA_W-1:0]               o_convolved_data,
    output logic                            o_convolved_data_valid,
    input  logic                            i_convolved_data_ready,
    input  logic                            i_coef_wr,
    input  logic [3:0]                      i_coef_addr,
    input  logic [COEF_W-1:0]               i_coef_data,
    input  logic                            i_coef_commit,
    output logic                            o_coef_busy,
    output conv_state_e                     o_fsm_state
);

    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int ROW_W  = PROD_W + 2;
    localparam int ACC_W  = DATA_W + COEF_W + 5;

    // ---------------- register banks ----------------
    logic signed [COEF_W-1:0] shd_coef_q [KERNEL_TAPS];
    logic signed [COEF_W-1:0] shd_coef_d [KERNEL_TAPS];
    logic signed [COEF_W-1:0] act_coef_q [KERNEL_TAPS];
    logic [NORM_W-1:0]        shd_mul_q, shd_mul_d, act_mul_q;
    logic [4:0]               shd_shift_q, shd_shift_d, act_shift_q;

    conv_state_e state_q;
    logic        busy_q;

    // ---------------- pipeline ----------------
    logic                     s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
    logic signed [PROD_W-1:0] prod_d     [KERNEL_TAPS];
    logic signed [PROD_W-1:0] s1_prod_q  [KERNEL_TAPS];
    logic signed [ROW_W-1:0]  row_d      [3];
    logic signed [ROW_W-1:0]  s2_row_q   [3];
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  s3_sum_q;
    logic [DATA_W-1:0]        norm_pix;
    logic [DATA_W-1:0]        out_data_q;

    logic adv;
    logic accept;
    logic drained;

    assign adv = !out_valid_q | i_convolved_data_ready;

    // The commit cycle itself is kept free of window acceptance so that the
    // window cannot straddle the bank switch.
    assign o_pixel_data_ready = adv & (state_q == RUN) & !i_coef_commit;
    assign accept             = i_pixel_data_valid & o_pixel_data_ready;

    // Pipeline is empty once S1..S3 hold nothing and the output leaves now.
    assign drained = !s1_valid_q & !s2_valid_q & !s3_valid_q &
                     (!out_valid_q | i_convolved_data_ready);

    // Shadow next-state: the write port is live in every FSM state, and APPLY
    // copies this value so a write in that same cycle is included.
    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            shd_coef_d[k] = shd_coef_q[k];
        end
        shd_mul_d   = shd_mul_q;
        shd_shift_d = shd_shift_q;
        if (i_coef_wr) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                if (i_coef_addr == 4'(k)) begin
                    shd_coef_d[k] = $signed(i_coef_data);
                end
            end
            if (i_coef_addr == ADDR_NORM_MUL) begin
                shd_mul_d = NORM_W'(i_coef_data);
            end else if (i_coef_addr == ADDR_NORM_SHIFT) begin
                shd_shift_d = i_coef_data[4:0];
            end
        end
    end

    // Commit FSM together with both banks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            busy_q      <= 1'b0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                shd_coef_q[k] <= COEF_W'(DEF_COEF);
                act_coef_q[k] <= COEF_W'(DEF_COEF);
            end
            shd_mul_q   <= NORM_W'(DEF_NORM_MUL);
            act_mul_q   <= NORM_W'(DEF_NORM_MUL);
            shd_shift_q <= 5'(DEF_NORM_SHIFT);
            act_shift_q <= 5'(DEF_NORM_SHIFT);
        end else begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                shd_coef_q[k] <= shd_coef_d[k];
            end
            shd_mul_q   <= shd_mul_d;
            shd_shift_q <= shd_shift_d;
            case (state_q)
                RUN: begin
                    if (i_coef_commit) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    for (int k = 0; k < KERNEL_TAPS; k++) begin
                        act_coef_q[k] <= shd_coef_d[k];
                    end
                    act_mul_q   <= shd_mul_d;
                    act_shift_q <= shd_shift_d;
                    state_q     <= RUN;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_coef_busy = busy_q;
    assign o_fsm_state = state_q;

    // S1..S3 arithmetic. Pixels are zero-extended so they stay non-negative.
    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            prod_d[k] = PROD_W'($signed({1'b0, i_pixel_data[k*DATA_W +: DATA_W]})) *
                        PROD_W'(act_coef_q[k]);
        end
        for (int r = 0; r < 3; r++) begin
            row_d[r] = ROW_W'(s1_prod_q[3*r]) + ROW_W'(s1_prod_q[3*r+1]) +
                       ROW_W'(s1_prod_q[3*r+2]);
        end
        sum_d = ACC_W'(s2_row_q[0]) + ACC_W'(s2_row_q[1]) + ACC_W'(s2_row_q[2]);
    end

    conv_normalize #(
        .DATA_W (DATA_W),
        .NORM_W (NORM_W),
        .ACC_W  (ACC_W)
    ) u_norm (
        .sum_i        (s3_sum_q),
        .norm_mul_i   (act_mul_q),
        .norm_shift_i (act_shift_q),
        .pixel_o      (norm_pix)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                s1_prod_q[k] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                s2_row_q[r] <= '0;
            end
            s3_sum_q    <= '0;
            out_data_q  <= '0;
        end else if (adv) begin
            s1_valid_q  <= accept;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                s1_prod_q[k] <= prod_d[k];
            end
            for (int r = 0; r < 3; r++) begin
                s2_row_q[r] <= row_d[r];
            end
            s3_sum_q    <= sum_d;
            if (s3_valid_q) begin
                out_data_q <= norm_pix;
            end
        end
    end

    assign o_convolved_data       = out_data_q;
    assign o_convolved_data_valid = out_valid_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Self-checking bench for conv3x3_filter (default widths 8/8/8).
// Expected pixels come from a plain-arithmetic model of the filter and from
// hand-computed table constants; CONV_SATURATE_EN selects the clamp/wrap form.
module tb_conv3x3_filter;

    typedef struct {
        logic [71:0] win;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [71:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  conv_data;
    logic        conv_valid;
    logic        conv_ready;
    logic        coef_wr;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        coef_commit;
    logic        coef_busy;
    logic [1:0]  fsm_state;

    conv3x3_filter #(.DATA_W(8), .COEF_W(8), .NORM_W(8)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_pixel_data           (pix_data),
        .i_pixel_data_valid     (pix_valid),
        .o_pixel_data_ready     (pix_ready),
        .o_convolved_data       (conv_data),
        .o_convolved_data_valid (conv_valid),
        .i_convolved_data_ready (conv_ready),
        .i_coef_wr              (coef_wr),
        .i_coef_addr            (coef_addr),
        .i_coef_data            (coef_data),
        .i_coef_commit          (coef_commit),
        .o_coef_busy            (coef_busy),
        .o_fsm_state            (fsm_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_cnt = 0;
    logic [7:0] exp_q[$];

    // Model register banks
    int m_shd_coef[9];
    int m_act_coef[9];
    int m_shd_mul, m_act_mul, m_shd_sh, m_act_sh;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_pix(input logic [71:0] w);
        longint s;
        longint t;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            s += longint'(w[k*8 +: 8]) * longint'(m_act_coef[k]);
        end
        t = s * longint'(m_act_mul);
        if (m_act_sh != 0) t += longint'(1) <<< (m_act_sh - 1);
        t = t >>> m_act_sh;
`ifdef CONV_SATURATE_EN
        if (t < 0) return 8'd0;
        if (t > 255) return 8'd255;
`endif
        return t[7:0];
    endfunction

    function automatic logic [71:0] fill(input int v);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v);
        return w;
    endfunction

    // Window by column: left, middle, right values on every row.
    function automatic logic [71:0] lr(input int l, input int m, input int r);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) begin
            w[k*8 +: 8] = (k % 3 == 0) ? 8'(l) : ((k % 3 == 1) ? 8'(m) : 8'(r));
        end
        return w;
    endfunction

    function automatic void model_defaults();
        for (int k = 0; k < 9; k++) begin
            m_shd_coef[k] = 1;
            m_act_coef[k] = 1;
        end
        m_shd_mul = 57; m_act_mul = 57;
        m_shd_sh  = 9;  m_act_sh  = 9;
    endfunction

    function automatic void model_apply();
        for (int k = 0; k < 9; k++) m_act_coef[k] = m_shd_coef[k];
        m_act_mul = m_shd_mul;
        m_act_sh  = m_shd_sh;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard ----------------
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    initial begin : scoreboard
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", conv_valid, 1);
                    check("hold_data", conv_data, prev_data);
                end
                if (conv_valid && !conv_ready) check("stall_in_ready", pix_ready, 0);
                if (coef_busy) check("busy_in_ready", pix_ready, 0);
                if (pix_valid && pix_ready) exp_q.push_back(model_pix(pix_data));
                if (conv_valid && conv_ready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got %0d expected no output", conv_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", conv_data, e);
                    end
                end
                prev_stall = conv_valid && !conv_ready;
                prev_data  = conv_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [71:0] w);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = w;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = pix_ready;
            tick();
            n++;
        end
        pix_valid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic get_output(output logic [7:0] v);
        bit got;
        int n;
        got = 0;
        n = 0;
        v = '0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (conv_valid && conv_ready) begin
                got = 1;
                v = conv_data;
            end
            n++;
        end
        check("output_seen", got, 1);
        tick();
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        coef_wr = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_wr = 1'b0;
        if (a < 4'd9) m_shd_coef[a] = int'($signed(d));
        else if (a == 4'd9) m_shd_mul = int'(d);
        else if (a == 4'd10) m_shd_sh = int'(d) & 31;
    endtask

    task automatic commit_wait();
        int n;
        n = 0;
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        while (coef_busy && n < 100) begin
            tick();
            n++;
        end
        check("commit_done", coef_busy, 0);
        model_apply();
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || conv_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    // ---------------- main test ----------------
    vec_t tbl[10];
    int sob[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int acc_cyc;
    int oc[$];
    int bc;
    int snap;
    int n;
    bit sdone;
    logic [7:0] v;

    initial begin : main
        tbl[0] = '{fill(100), 8'd100, "all100"};
        tbl[1] = '{fill(255), 8'd255, "all255"};
        tbl[2] = '{fill(0),   8'd0,   "all0"};
        tbl[3] = '{fill(9),   8'd9,   "all9"};
        tbl[4] = '{72'h08_07_06_05_04_03_02_01_00, 8'd4, "ramp"};
        tbl[5] = '{lr(0, 123, 50), 8'd200, "sobel_pos"};
`ifdef CONV_SATURATE_EN
        tbl[6] = '{lr(50, 0, 0),   8'd0,   "sobel_neg"};
        tbl[9] = '{lr(0, 0, 255),  8'd255, "sobel_big"};
`else
        tbl[6] = '{lr(50, 0, 0),   8'd56,  "sobel_neg"};
        tbl[9] = '{lr(0, 0, 255),  8'd252, "sobel_big"};
`endif
        tbl[7] = '{fill(77),       8'd0,   "sobel_flat"};
        tbl[8] = '{lr(10, 200, 20), 8'd40, "sobel_small"};

        pix_data = '0; pix_valid = 1'b0; conv_ready = 1'b1;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
        model_defaults();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_valid", conv_valid, 0);
        check("rst_data", conv_data, 0);
        check("rst_busy", coef_busy, 0);
        check("rst_state", fsm_state, 0);
        check("rst_ready", pix_ready, 1);

        // Latency and throughput: 6 back-to-back windows.
        acc_cyc = -1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(fill(100));
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (acc_cyc < 0 && pix_valid && pix_ready) acc_cyc = cyc;
                    if (conv_valid && conv_ready) oc.push_back(cyc);
                end
            end
        join
        tick();
        check("lat_out_count", oc.size(), 6);
        if (oc.size() == 6) begin
            check("latency", oc[0] - acc_cyc, 4);
            check("throughput", oc[5] - oc[0], 5);
        end

        // Default-bank table.
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].win);
            get_output(v);
            check(tbl[i].name, v, tbl[i].exp);
        end

        // Commit on an empty pipeline with a tap write landing in APPLY.
        bc = 0;
        coef_commit = 1'b1;
        @(negedge clk);
        check("commit_cycle_ready", pix_ready, 0);
        check("commit_cycle_busy", coef_busy, 0);
        tick();
        coef_commit = 1'b0;
        @(negedge clk);
        if (coef_busy) bc++;
        check("drain_state", fsm_state, 1);
        tick();
        coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 8'd3;
        @(negedge clk);
        if (coef_busy) bc++;
        check("apply_state", fsm_state, 2);
        tick();
        coef_wr = 1'b0;
        @(negedge clk);
        if (coef_busy) bc++;
        tick();
        check("commit_busy_cycles", bc, 2);
        m_shd_coef[4] = 3;
        model_apply();
        send(fill(9));
        get_output(v);
        check("apply_write", v, 11);

        // Sobel-x bank.
        for (int k = 0; k < 9; k++) write_reg(4'(k), 8'(sob[k]));
        write_reg(4'd9, 8'd1);
        write_reg(4'd10, 8'd0);
        commit_wait();
        for (int i = 5; i < 10; i++) begin
            send(tbl[i].win);
            get_output(v);
            check(tbl[i].name, v, tbl[i].exp);
        end

        // Output stall for 5 cycles mid-stream.
        snap = out_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(lr(0, i * 3, i * 7 + 1));
            end
            begin
                repeat (3) tick();
                conv_ready = 1'b0;
                repeat (5) tick();
                conv_ready = 1'b1;
            end
        join
        wait_empty();
        check("stall_count", out_cnt - snap, 8);

        // Commit with three windows in flight.
        for (int k = 0; k < 9; k++) write_reg(4'(k), 8'd2);
        write_reg(4'd9, 8'd1);
        write_reg(4'd10, 8'd2);
        snap = out_cnt;
        send(lr(0, 0, 10));
        send(lr(0, 0, 20));
        send(lr(0, 0, 30));
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        check("inflight_busy", coef_busy, 1);
        n = 0;
        while (coef_busy && n < 50) begin
            tick();
            n++;
        end
        check("inflight_busy_clear", coef_busy, 0);
        check("inflight_outputs", out_cnt - snap, 3);
        model_apply();
        send(fill(10));
        get_output(v);
        check("new_bank", v, 45);

        // Randomised traffic under two random banks.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 9; k++) write_reg(4'(k), 8'($urandom_range(0, 255)));
            write_reg(4'd9, 8'($urandom_range(0, 255)));
            write_reg(4'd10, {3'($urandom_range(0, 7)), 5'($urandom_range(4, 14))});
            write_reg(4'($urandom_range(11, 15)), 8'($urandom_range(0, 255)));
            commit_wait();
            sdone = 0;
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send({8'($urandom), 32'($urandom), 32'($urandom)});
                    end
                    sdone = 1;
                end
                begin
                    while (!sdone) begin
                        conv_ready = ($urandom_range(0, 3) != 0);
                        tick();
                    end
                    conv_ready = 1'b1;
                end
            join
            wait_empty();
        end

        // Reset during a stall with a commit pending.
        write_reg(4'd0, 8'd5);
        conv_ready = 1'b0;
        send(fill(40));
        repeat (5) tick();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        repeat (2) tick();
        check("pre_reset_busy", coef_busy, 1);
        check("pre_reset_valid", conv_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_valid", conv_valid, 0);
        check("reset_busy", coef_busy, 0);
        check("reset_data", conv_data, 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        conv_ready = 1'b1;
        model_defaults();
        send(fill(9));
        get_output(v);
        check("reset_defaults", v, 9);

        wait_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        failures++;
        $display("FAIL watchdog: got timeout expected test end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
